pit_bus_ctrl: RTL and testbench

//  CPU-side bus controller for the 8254 timer: decodes CS/RD/WR/A1:A0, routes control words to the three counters,

---
 rtl/pit_pkg.sv | 16 +
 rtl/pit_chan_if.sv | 85 ++++++++
 rtl/pit_bus_ctrl.sv | 117 +++++++++++
 tb/tb_pit_bus_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pit_pkg.sv
// Shared types and constants for the 8254 bus controller.
// Holds the RW access-format enum, address/select codes and control-word width.
package pit_pkg;

  typedef enum logic [1:0] {
    RW_LATCH   = 2'b00,
    RW_LSB     = 2'b01,
    RW_MSB     = 2'b10,
    RW_LSB_MSB = 2'b11
  } rw_e;

  localparam logic [1:0] ADDR_CTRL   = 2'b11;
  localparam logic [1:0] SC_READBACK = 2'b11;
  localparam int         CW_W        = 6;

endpackage

// File: rtl/pit_chan_if.sv
// Per-counter byte sequencer: write flip-flop, held LSB, read flip-flop, latch.
// Ports: clk/rst, decoded strobes in, rw format, din, live rdata; load request/value and read byte out.
module pit_chan_if
  import pit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cwWr,
  input  logic        latchCmd,
  input  logic        wrEv,
  input  logic        rdEv,
  input  rw_e         rw,
  input  logic [7:0]  din,
  input  logic [15:0] rdata,
  output logic        loadReq,
  output logic [15:0] loadVal,
  output logic [7:0]  rdByte
);

  logic        wrFF;
  logic        rdFF;
  logic        latched;
  logic        rdLast;
  logic [7:0]  lsbHold;
  logic [15:0] latchVal;
  logic [15:0] src;

  assign src = latched ? latchVal : rdata;

  always_comb begin
    loadReq = 1'b0;
    loadVal = 16'h0000;
    rdByte  = src[7:0];
    rdLast  = 1'b1;
    unique case (rw)
      RW_LSB: begin
        loadReq = wrEv;
        loadVal = {8'h00, din};
      end
      RW_MSB: begin
        loadReq = wrEv;
        loadVal = {din, 8'h00};
        rdByte  = src[15:8];
      end
      RW_LSB_MSB: begin
        loadReq = wrEv & wrFF;
        loadVal = {din, lsbHold};
        rdByte  = rdFF ? src[15:8] : src[7:0];
        rdLast  = rdFF;
      end
      RW_LATCH: begin
        loadReq = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrFF     <= 1'b0;
      rdFF     <= 1'b0;
      latched  <= 1'b0;
      lsbHold  <= 8'h00;
      latchVal <= 16'h0000;
    end else if (cwWr) begin
      wrFF    <= 1'b0;
      rdFF    <= 1'b0;
      latched <= 1'b0;
    end else begin
      // a second latch before the first is fully read is ignored
      if (latchCmd && !latched) begin
        latched  <= 1'b1;
        latchVal <= rdata;
      end
      if (wrEv && rw == RW_LSB_MSB) begin
        wrFF <= ~wrFF;
        if (!wrFF) lsbHold <= din;
      end
      if (rdEv) begin
        if (rw == RW_LSB_MSB) rdFF <= ~rdFF;
        if (rdLast) latched <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/pit_bus_ctrl.sv
// 8254 host bus controller: strobe edge detect, address decode, count byte mux, dout.
// Optional PIT_READBACK_EN macro enables the SC=11 read-back latch command.
module pit_bus_ctrl
  import pit_pkg::*;
#(
  parameter int NUM_CNT = 3,
  parameter int DW      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cs_n,
  input  logic                    wr_n,
  input  logic                    rd_n,
  input  logic [1:0]              addr,
  input  logic [DW-1:0]           din,
  output logic [DW-1:0]           dout,
  output logic [CW_W*NUM_CNT-1:0] cw,
  output logic [NUM_CNT-1:0]      cw_wr,
  output logic [15:0]             cnt_wdata,
  output logic [NUM_CNT-1:0]      cnt_load,
  input  logic [16*NUM_CNT-1:0]   cnt_rdata
);

  logic wrAct, rdAct, wrPrev, rdPrev;
  logic wrEv, rdEv, ctlEv, rdHit;
  logic [1:0] sc;
  rw_e rwIn;
  logic [NUM_CNT-1:0] cwSel, latchSel;
  logic [NUM_CNT-1:0] cntWr, cntRd, loadReq;
  logic [15:0] loadVal [NUM_CNT];
  logic [7:0] rdByte [NUM_CNT];
  logic [CW_W-1:0] cwReg [NUM_CNT];
  logic [15:0] wdNext;
  logic [DW-1:0] rdNext;

  assign wrAct = ~(cs_n | wr_n);
  assign rdAct = ~(cs_n | rd_n);
  assign wrEv  = wrAct & ~wrPrev;
  // a read overlapping an active write is swallowed
  assign rdEv  = rdAct & ~rdPrev & ~wrAct;
  assign ctlEv = wrEv & (addr == ADDR_CTRL);
  assign sc    = din[7:6];
  assign rwIn  = rw_e'(din[5:4]);

  always_comb begin
    cwSel    = '0;
    latchSel = '0;
    cntWr    = '0;
    cntRd    = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      if (ctlEv && sc == 2'(i)) begin
        cwSel[i]    = (rwIn != RW_LATCH);
        latchSel[i] = (rwIn == RW_LATCH);
      end
`ifdef PIT_READBACK_EN
      if (ctlEv && sc == SC_READBACK && !din[5] && din[1+i])
        latchSel[i] = 1'b1;
`endif
      cntWr[i] = wrEv && (addr == 2'(i));
      cntRd[i] = rdEv && (addr == 2'(i));
    end
  end

  always_comb begin
    wdNext = cnt_wdata;
    rdNext = '0;
    rdHit  = (addr == ADDR_CTRL);
    for (int i = 0; i < NUM_CNT; i++) begin
      if (loadReq[i]) wdNext = loadVal[i];
      if (addr == 2'(i)) begin
        rdHit  = 1'b1;
        rdNext = rdByte[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CNT; g++) begin : gChan
    assign cw[g*CW_W +: CW_W] = cwReg[g];

    pit_chan_if uChan (
      .clk      (clk),
      .rst      (rst),
      .cwWr     (cwSel[g]),
      .latchCmd (latchSel[g]),
      .wrEv     (cntWr[g]),
      .rdEv     (cntRd[g]),
      .rw       (rw_e'(cwReg[g][5:4])),
      .din      (din[7:0]),
      .rdata    (cnt_rdata[16*g +: 16]),
      .loadReq  (loadReq[g]),
      .loadVal  (loadVal[g]),
      .rdByte   (rdByte[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPrev    <= 1'b0;
      rdPrev    <= 1'b0;
      dout      <= '0;
      cw_wr     <= '0;
      cnt_load  <= '0;
      cnt_wdata <= 16'h0000;
      for (int i = 0; i < NUM_CNT; i++) cwReg[i] <= '0;
    end else begin
      wrPrev    <= wrAct;
      rdPrev    <= rdAct;
      cw_wr     <= cwSel;
      cnt_load  <= loadReq;
      cnt_wdata <= wdNext;
      for (int i = 0; i < NUM_CNT; i++)
        if (cwSel[i]) cwReg[i] <= din[CW_W-1:0];
      if (rdEv && rdHit) dout <= rdNext;
    end
  end

endmodule

// File: tb/tb_pit_bus_ctrl.sv
// Self-checking bench for pit_bus_ctrl: directed scenarios then random bus traffic.
// Expected values come from a transaction-level model of the 8254 host interface.
module tb_pit_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1;
  logic        wr_n = 1'b1;
  logic        rd_n = 1'b1;
  logic [1:0]  addr = 2'b00;
  logic [7:0]  din = 8'h00;
  logic [7:0]  dout;
  logic [17:0] cw;
  logic [2:0]  cw_wr;
  logic [15:0] cnt_wdata;
  logic [2:0]  cnt_load;
  logic [47:0] cnt_rdata = '0;

  always #5 clk = ~clk;

  pit_bus_ctrl #(.NUM_CNT(3), .DW(8)) dut (
    .clk(clk), .rst(rst), .cs_n(cs_n), .wr_n(wr_n), .rd_n(rd_n),
    .addr(addr), .din(din), .dout(dout), .cw(cw), .cw_wr(cw_wr),
    .cnt_wdata(cnt_wdata), .cnt_load(cnt_load), .cnt_rdata(cnt_rdata)
  );

  int checks = 0;
  int errors = 0;

  logic [5:0]  mCw [3];
  bit          mWph [3];
  bit          mRph [3];
  bit          mLat [3];
  logic [7:0]  mLsb [3];
  logic [15:0] mLval [3];
  logic [15:0] mWdata;
  logic [7:0]  mDout;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic mReset;
    for (int i = 0; i < 3; i++) begin
      mCw[i] = '0; mWph[i] = 0; mRph[i] = 0; mLat[i] = 0;
      mLsb[i] = '0; mLval[i] = '0;
    end
    mWdata = '0;
    mDout  = '0;
  endtask

  task automatic mLatch(input int c);
    if (!mLat[c]) begin
      mLat[c]  = 1;
      mLval[c] = cnt_rdata[16*c +: 16];
    end
  endtask

  task automatic checkIdle(input string tag);
    check({tag, ".cw_wr"}, cw_wr, 0);
    check({tag, ".load"}, cnt_load, 0);
    check({tag, ".cw"}, cw, {mCw[2], mCw[1], mCw[0]});
    check({tag, ".wdata"}, cnt_wdata, mWdata);
    check({tag, ".dout"}, dout, mDout);
  endtask

  task automatic busWr(input logic [1:0] a, input logic [7:0] d);
    logic [2:0] eCwWr;
    logic [2:0] eLoad;
    int c;
    int rw;
    eCwWr = '0;
    eLoad = '0;
    cs_n = 0; wr_n = 0; addr = a; din = d;
    if (a == 2'b11) begin
      c = int'(d[7:6]);
      if (c < 3) begin
        if (d[5:4] != 2'b00) begin
          mCw[c] = d[5:0]; eCwWr[c] = 1'b1;
          mWph[c] = 0; mRph[c] = 0; mLat[c] = 0;
        end else mLatch(c);
      end
`ifdef PIT_READBACK_EN
      else if (!d[5]) begin
        for (int i = 0; i < 3; i++) if (d[1+i]) mLatch(i);
      end
`endif
    end else begin
      c  = int'(a);
      rw = int'(mCw[c][5:4]);
      if (rw == 1) begin
        mWdata = {8'h00, d}; eLoad[c] = 1'b1;
      end else if (rw == 2) begin
        mWdata = {d, 8'h00}; eLoad[c] = 1'b1;
      end else if (rw == 3) begin
        if (mWph[c]) begin
          mWdata = {d, mLsb[c]}; eLoad[c] = 1'b1;
        end else mLsb[c] = d;
        mWph[c] = !mWph[c];
      end
    end
    step;
    check("wr.cw_wr", cw_wr, eCwWr);
    check("wr.load", cnt_load, eLoad);
    check("wr.wdata", cnt_wdata, mWdata);
    check("wr.cw", cw, {mCw[2], mCw[1], mCw[0]});
    cs_n = 1; wr_n = 1;
    step;
    checkIdle("wrIdle");
  endtask

  task automatic busRd(input logic [1:0] a);
    logic [15:0] src;
    int c;
    bit last;
    cs_n = 0; rd_n = 0; addr = a;
    if (a == 2'b11) mDout = 8'h00;
    else begin
      c    = int'(a);
      src  = mLat[c] ? mLval[c] : cnt_rdata[16*c +: 16];
      last = 1;
      case (int'(mCw[c][5:4]))
        2: mDout = src[15:8];
        3: begin
          mDout = mRph[c] ? src[15:8] : src[7:0];
          last  = mRph[c];
          mRph[c] = !mRph[c];
        end
        default: mDout = src[7:0];
      endcase
      if (last) mLat[c] = 0;
    end
    step;
    check("rd.dout", dout, mDout);
    cs_n = 1; rd_n = 1;
    step;
    checkIdle("rdIdle");
  endtask

  task automatic doReset;
    rst = 1;
    step;
    step;
    rst = 0;
    mReset();
  endtask

  initial begin
    int loads;
    int op;
    mReset();
    doReset();
    checkIdle("reset");

    busWr(2'b11, 8'h34);
    check("cw0", cw[5:0], 6'h34);
    busWr(2'b00, 8'hE8);
    busWr(2'b00, 8'h03);
    check("load03E8", cnt_wdata, 16'h03E8);

    busWr(2'b11, 8'h50);
    busWr(2'b01, 8'h7F);
    check("lsbOnly", cnt_wdata, 16'h007F);
    busWr(2'b11, 8'h60);
    busWr(2'b01, 8'h12);
    check("msbOnly", cnt_wdata, 16'h1200);

    cnt_rdata[15:0] = 16'hABCD;
    busWr(2'b11, 8'h00);
    cnt_rdata[15:0] = 16'h1111;
    busWr(2'b11, 8'h00);
    busRd(2'b00);
    check("latLsb", dout, 8'hCD);
    busRd(2'b00);
    check("latMsb", dout, 8'hAB);
    busRd(2'b00);
    check("liveLsb", dout, 8'h11);
    busRd(2'b11);
    check("ctrlRd", dout, 8'h00);

    busWr(2'b11, 8'hB4);
    busWr(2'b10, 8'h99);
    doReset();
    checkIdle("midRst");
    busWr(2'b11, 8'hB4);
    busWr(2'b10, 8'h05);
    busWr(2'b10, 8'h00);
    check("rstLoad", cnt_wdata, 16'h0005);

    busWr(2'b11, 8'h50);
    cs_n = 0; wr_n = 0; addr = 2'b01; din = 8'h3C;
    loads = 0;
    for (int i = 0; i < 10; i++) begin
      step;
      if (cnt_load[1]) loads++;
    end
    cs_n = 1; wr_n = 1;
    step;
    mWdata = 16'h003C;
    check("heldWrLoads", loads, 1);
    checkIdle("heldWr");

    busWr(2'b11, 8'h34);
    cnt_rdata = {16'h3333, 16'h2222, 16'h1111};
    busWr(2'b11, 8'hCE);
    cnt_rdata = {16'h6666, 16'h5555, 16'h4444};
    busRd(2'b01);
`ifdef PIT_READBACK_EN
    check("rbCnt1", dout, 8'h22);
`else
    check("rbCnt1", dout, 8'h55);
`endif
    busRd(2'b00);
    busRd(2'b00);
    busRd(2'b10);
    busRd(2'b10);

    for (int n = 0; n < 400; n++) begin
      cnt_rdata = {16'($urandom), 16'($urandom), 16'($urandom)};
      op = int'($urandom_range(0, 2));
      if (op == 0) busWr(2'b11, 8'($urandom));
      else if (op == 1) busWr(2'($urandom_range(0, 2)), 8'($urandom));
      else busRd(2'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
